// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the cache data port.
// The arbiter uses the slave modport; the requester/cache environment uses master.
interface dmem_arbiter_if;
  logic        I_m0_req;
  logic [31:0] I_m0_addr;
  logic [31:0] I_m0_wdata;
  logic [3:0]  I_m0_wmask;
  logic        I_m0_we;
  logic [31:0] O_m0_rdata;
  logic        O_m0_stall;

  logic        I_m1_req;
  logic [31:0] I_m1_addr;
  logic [31:0] I_m1_wdata;
  logic [3:0]  I_m1_wmask;
  logic        I_m1_we;
  logic [31:0] O_m1_rdata;
  logic        O_m1_stall;

  logic        O_s_req;
  logic [31:0] O_s_addr;
  logic [31:0] O_s_wdata;
  logic [3:0]  O_s_wmask;
  logic        O_s_we;
  logic [31:0] I_s_rdata;
  logic        I_s_stall;

  modport slave (
    input  I_m0_req, I_m0_addr, I_m0_wdata, I_m0_wmask, I_m0_we,
    input  I_m1_req, I_m1_addr, I_m1_wdata, I_m1_wmask, I_m1_we,
    input  I_s_rdata, I_s_stall,
    output O_m0_rdata, O_m0_stall, O_m1_rdata, O_m1_stall,
    output O_s_req, O_s_addr, O_s_wdata, O_s_wmask, O_s_we
  );

  modport master (
    output I_m0_req, I_m0_addr, I_m0_wdata, I_m0_wmask, I_m0_we,
    output I_m1_req, I_m1_addr, I_m1_wdata, I_m1_wmask, I_m1_we,
    output I_s_rdata, I_s_stall,
    input  O_m0_rdata, O_m0_stall, O_m1_rdata, O_m1_stall,
    input  O_s_req, O_s_addr, O_s_wdata, O_s_wmask, O_s_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter sharing the cache data port between the CPU (m0) and a secondary requester (m1).
// Define DMEM_ARB_RR_EN for round-robin; otherwise fixed priority with an m1 starvation guard.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          I_clk,
  input  logic          I_rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  state_e      state_q;
  logic        owner_q;
  logic        lastGrant_q;
  logic        lastGrant_d;
  logic [7:0]  starveCnt_q;
  logic [7:0]  starveCnt_d;

  logic        sReq_q;
  logic [31:0] sAddr_q;
  logic [31:0] sWdata_q;
  logic [3:0]  sWmask_q;
  logic        sWe_q;

  logic        anyReq;
  logic        grant;
  logic        m1Wins;
  logic        m0Done;
  logic        m1Done;

  assign anyReq = bus.I_m0_req | bus.I_m1_req;
  assign grant  = (state_q == IDLE) & anyReq;

  // Winner selection and bookkeeping for the next arbitration.
  always_comb begin
    m1Wins      = 1'b0;
    starveCnt_d = starveCnt_q;
`ifdef DMEM_ARB_RR_EN
    if (bus.I_m0_req && bus.I_m1_req) begin
      m1Wins = ~lastGrant_q;
    end else begin
      m1Wins = bus.I_m1_req;
    end
    starveCnt_d = '0;
`else
    m1Wins = bus.I_m1_req & (~bus.I_m0_req | (starveCnt_q >= StarveMax));
    if (!bus.I_m1_req) begin
      starveCnt_d = '0;
    end else if (state_q == IDLE) begin
      if (m1Wins) begin
        starveCnt_d = '0;
      end else if (starveCnt_q < StarveMax) begin
        starveCnt_d = starveCnt_q + 8'd1;
      end
    end
`endif
    lastGrant_d = grant ? m1Wins : lastGrant_q;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      starveCnt_q <= '0;
      sReq_q      <= 1'b0;
      sAddr_q     <= '0;
      sWdata_q    <= '0;
      sWmask_q    <= '0;
      sWe_q       <= 1'b0;
    end else begin
      lastGrant_q <= lastGrant_d;
      starveCnt_q <= starveCnt_d;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q  <= m1Wins;
            sReq_q   <= 1'b1;
            sAddr_q  <= m1Wins ? bus.I_m1_addr  : bus.I_m0_addr;
            sWdata_q <= m1Wins ? bus.I_m1_wdata : bus.I_m0_wdata;
            sWmask_q <= m1Wins ? bus.I_m1_wmask : bus.I_m0_wmask;
            sWe_q    <= m1Wins ? bus.I_m1_we    : bus.I_m0_we;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          // Fields stay frozen until the cache accepts; then they return to zero.
          if (!bus.I_s_stall) begin
            sReq_q   <= 1'b0;
            sAddr_q  <= '0;
            sWdata_q <= '0;
            sWmask_q <= '0;
            sWe_q    <= 1'b0;
            state_q  <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Completion is suppressed while reset is held so stalls simply follow the requests.
  assign m0Done = (state_q == RESP) & ~owner_q & ~I_rst;
  assign m1Done = (state_q == RESP) &  owner_q & ~I_rst;

  assign bus.O_m0_stall = bus.I_m0_req & ~m0Done;
  assign bus.O_m1_stall = bus.I_m1_req & ~m1Done;
  assign bus.O_m0_rdata = m0Done ? bus.I_s_rdata : 32'd0;
  assign bus.O_m1_rdata = m1Done ? bus.I_s_rdata : 32'd0;

  assign bus.O_s_req   = sReq_q;
  assign bus.O_s_addr  = sAddr_q;
  assign bus.O_s_wdata = sWdata_q;
  assign bus.O_s_wmask = sWmask_q;
  assign bus.O_s_we    = sWe_q;

endmodule
